// File: rtl/writeback_unit_pkg.sv
// Shared opcode/funct3 constants, the writeback entry type and the load
// extraction helper used by the writeback stage.
package wb_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LD  = 3'd3;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_LWU = 3'd6;

  typedef struct packed {
    logic                we;
    logic [4:0]          addr;
    logic [XLEN_MAX-1:0] data;
  } wb_entry_t;

  typedef struct packed {
    logic                ok;
    logic [XLEN_MAX-1:0] data;
  } ld_res_t;

  // Result is always extended to 64 bits; callers truncate to their XLEN.
  function automatic ld_res_t load_extend(input logic [2:0]  funct3,
                                          input logic [2:0]  lane,
                                          input logic [63:0] word,
                                          input logic        is64);
    logic [63:0] sh;
    ld_res_t     r;
    sh     = word >> {lane, 3'b000};
    r.ok   = 1'b1;
    r.data = '0;
    case (funct3)
      F3_LB:  r.data = {{56{sh[7]}}, sh[7:0]};
      F3_LH:  r.data = {{48{sh[15]}}, sh[15:0]};
      F3_LW:  r.data = {{32{sh[31]}}, sh[31:0]};
      F3_LBU: r.data = {56'd0, sh[7:0]};
      F3_LHU: r.data = {48'd0, sh[15:0]};
      F3_LWU: begin
        r.ok   = is64;
        r.data = {32'd0, sh[31:0]};
      end
      F3_LD: begin
        r.ok   = is64;
        r.data = sh;
      end
      default: r.ok = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/writeback_unit_queue.sv
// Generic synchronous FIFO with age-ordered read-out of every slot so the
// parent can search pending entries.
module wb_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 38
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic [W-1:0]              din_i,
  input  logic                      pop_i,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [W-1:0]              head_o,
  output logic [DEPTH-1:0][W-1:0]   ent_o,
  output logic [DEPTH-1:0]          vld_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    if (push_i) wr_d = nxt(wr_q);
    if (pop_i)  rd_d = nxt(rd_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

  // Slot i of the read-out is the i-th oldest entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      int sum;
      sum = int'(rd_q) + i;
      if (sum >= DEPTH) sum = sum - DEPTH;
      ent_o[i] = mem_q[PW'(sum)];
      vld_o[i] = (CW'(i) < cnt_q);
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// RISC-V writeback stage: forms the register-file write for each instruction,
// queues it, drains it with handshakes and offers forwarding over pending writes.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 2,
  parameter int PC_STEP = 1,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_ir,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [XLEN-1:0]    in_alu,
  input  logic [XLEN-1:0]    in_mem,
  output logic               rf_we,
  output logic [4:0]         rf_addr,
  output logic [XLEN-1:0]    rf_data,
  input  logic               rf_ready,
  input  logic [4:0]         lk_addr,
  output logic               lk_hit,
  output logic [XLEN-1:0]    lk_data,
  output logic [COUNT_W-1:0] retired,
  output logic               ld_err
);

  localparam int EW = XLEN + 6;

  logic [6:0]          opcode;
  logic [4:0]          rd;
  logic [2:0]          funct3;
  logic [2:0]          lane;
  logic [63:0]         mem64;
  logic [XLEN-1:0]     link;
  ld_res_t             ld_r;
  wb_entry_t           ent_d;
  logic                ld_bad;

  logic                push, pop, q_full, q_empty;
  logic [EW-1:0]       push_data, head;
  logic [DEPTH-1:0][EW-1:0] ents;
  logic [DEPTH-1:0]    ent_vld;
  logic                head_we;

  logic [COUNT_W-1:0]  retired_q, retired_d;
  logic                ld_err_q, ld_err_d;

  logic                unused_bits;

  assign opcode = in_ir[6:0];
  assign rd     = in_ir[11:7];
  assign funct3 = in_ir[14:12];
  assign lane   = (XLEN == 64) ? in_alu[2:0] : {1'b0, in_alu[1:0]};
  assign mem64  = 64'(in_mem);
  assign link   = in_pc + XLEN'(PC_STEP);
  assign ld_r   = load_extend(funct3, lane, mem64, XLEN == 64);

  always_comb begin
    ent_d.we   = 1'b1;
    ent_d.addr = rd;
    ent_d.data = 64'(in_alu);
    ld_bad     = 1'b0;
    case (opcode)
      OP_STORE, OP_BRANCH: begin
        ent_d.we   = 1'b0;
        ent_d.addr = 5'd0;
      end
      OP_JAL, OP_JALR: ent_d.data = 64'(link);
      OP_LOAD: begin
        ent_d.data = 64'(XLEN'(ld_r.data));
        ld_bad     = !ld_r.ok;
      end
      default: ;
    endcase
    if (rd == 5'd0 || ld_bad) ent_d.we = 1'b0;
  end

  assign unused_bits = ^{in_ir[31:15], ent_d.data, ld_r.data};
  assign push_data   = {ent_d.we, ent_d.addr, ent_d.data[XLEN-1:0]};

  // Input is gated only by occupancy so in_ready never depends on rf_ready.
  assign in_ready = !q_full && !rst;
  assign push     = in_valid && in_ready;
  assign head_we  = head[EW-1];
  assign pop      = !q_empty && (rf_ready || !head_we);

  wb_queue #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (push_data),
    .pop_i   (pop),
    .full_o  (q_full),
    .empty_o (q_empty),
    .head_o  (head),
    .ent_o   (ents),
    .vld_o   (ent_vld)
  );

  assign rf_we   = !q_empty && head_we;
  assign rf_addr = q_empty ? 5'd0 : head[EW-2 -: 5];
  assign rf_data = q_empty ? '0 : head[XLEN-1:0];

  // Oldest to youngest, so a later match overrides an earlier one.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && ents[i][EW-1] && (ents[i][EW-2 -: 5] == lk_addr) &&
          (lk_addr != 5'd0)) begin
        lk_hit  = 1'b1;
        lk_data = ents[i][XLEN-1:0];
      end
    end
  end

  always_comb begin
    retired_d = retired_q + COUNT_W'(pop);
    ld_err_d  = ld_err_q || (push && ld_bad);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      ld_err_q  <= 1'b0;
    end else begin
      retired_q <= retired_d;
      ld_err_q  <= ld_err_d;
    end
  end

  assign retired = retired_q;
  assign ld_err  = ld_err_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit (XLEN=32, DEPTH=2, PC_STEP=1, COUNT_W=4).
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ir, in_pc, in_alu, in_mem;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        rf_ready;
  logic [4:0]  lk_addr;
  logic        lk_hit;
  logic [31:0] lk_data;
  logic [3:0]  retired;
  logic        ld_err;

  int errors = 0;
  int checks = 0;

  writeback_unit #(
    .XLEN(32), .DEPTH(2), .PC_STEP(1), .COUNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ir(in_ir), .in_pc(in_pc), .in_alu(in_alu), .in_mem(in_mem),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .rf_ready(rf_ready),
    .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
    .retired(retired), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rdv,
                                     input logic [2:0] f3);
    return {17'd0, f3, rdv, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ir, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] mem);
    in_valid = 1'b1;
    in_ir    = ir;
    in_pc    = pc;
    in_alu   = alu;
    in_mem   = mem;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_ir    = '0;
  endtask

  localparam logic [6:0] ADDI = 7'b0010011;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ir = '0; in_pc = '0; in_alu = '0;
    in_mem = '0; rf_ready = 1'b0; lk_addr = '0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_rf_data", rf_data, 0);
    chk("rst_lk_hit", lk_hit, 0);
    chk("rst_retired", retired, 0);
    chk("rst_ld_err", ld_err, 0);
    rst = 1'b0; #1;
    chk("post_rst_in_ready", in_ready, 1);

    // ALU and JAL
    rf_ready = 1'b1;
    drive(mk(ADDI, 5, 0), 32'h0, 32'h10, 32'h0);
    tick();
    chk("addi_we", rf_we, 1);
    chk("addi_addr", rf_addr, 5);
    chk("addi_data", rf_data, 32'h10);
    drive(mk(7'b1101111, 1, 0), 32'h40, 32'h0, 32'h0);
    tick();
    chk("jal_we", rf_we, 1);
    chk("jal_addr", rf_addr, 1);
    chk("jal_data", rf_data, 32'h41);
    idle();
    tick();
    chk("t1_idle_we", rf_we, 0);
    chk("t1_retired", retired, 2);

    // Loads
    drive(mk(7'b0000011, 3, 0), 32'h0, 32'h101, 32'h80FF7F01);
    tick();
    chk("lb_addr", rf_addr, 3);
    chk("lb_data", rf_data, 32'h0000007F);
    drive(mk(7'b0000011, 3, 4), 32'h0, 32'h103, 32'h80FF7F01);
    tick();
    chk("lbu_data", rf_data, 32'h00000080);
    drive(mk(7'b0000011, 3, 1), 32'h0, 32'h102, 32'h80FF7F01);
    tick();
    chk("lh_data", rf_data, 32'hFFFF80FF);
    chk("ld_err_clear", ld_err, 0);
    drive(mk(7'b0000011, 3, 7), 32'h0, 32'h100, 32'h80FF7F01);
    tick();
    chk("badld_we", rf_we, 0);
    chk("badld_err", ld_err, 1);
    idle();
    tick();
    chk("t2_retired", retired, 6);

    // Suppressed writes drain even without rf_ready
    rf_ready = 1'b0;
    drive(mk(7'b0100011, 5, 2), 32'h0, 32'h20, 32'h0);
    tick();
    chk("sw_we", rf_we, 0);
    chk("sw_retired", retired, 6);
    drive(mk(7'b1100011, 4, 0), 32'h0, 32'h0, 32'h0);
    tick();
    chk("beq_we", rf_we, 0);
    chk("beq_retired", retired, 7);
    drive(mk(ADDI, 0, 0), 32'h0, 32'h55, 32'h0);
    tick();
    chk("x0_we", rf_we, 0);
    chk("x0_retired", retired, 8);
    idle();
    tick();
    chk("t3_retired", retired, 9);

    // Backpressure
    drive(mk(ADDI, 10, 0), 32'h0, 32'hA, 32'h0);
    #1;
    chk("bp_ready0", in_ready, 1);
    tick();
    drive(mk(ADDI, 11, 0), 32'h0, 32'hB, 32'h0);
    tick();
    chk("bp_full_ready", in_ready, 0);
    chk("bp_head_we", rf_we, 1);
    chk("bp_head_addr", rf_addr, 10);
    drive(mk(ADDI, 12, 0), 32'h0, 32'hC, 32'h0);
    tick();
    chk("bp_stall_ready", in_ready, 0);
    chk("bp_stall_addr", rf_addr, 10);
    rf_ready = 1'b1;
    #1;
    chk("bp_full_pop_ready", in_ready, 0);
    tick();
    chk("bp_after_pop_ready", in_ready, 1);
    chk("bp_w2_addr", rf_addr, 11);
    chk("bp_w2_data", rf_data, 32'hB);
    tick();
    idle();
    chk("bp_w3_addr", rf_addr, 12);
    chk("bp_w3_data", rf_data, 32'hC);
    tick();
    chk("bp_drained_we", rf_we, 0);
    chk("t4_retired", retired, 12);

    // Forwarding
    rf_ready = 1'b0;
    drive(mk(ADDI, 7, 0), 32'h0, 32'h11, 32'h0);
    tick();
    drive(mk(ADDI, 7, 0), 32'h0, 32'h22, 32'h0);
    tick();
    idle();
    lk_addr = 5'd7; #1;
    chk("fw_hit", lk_hit, 1);
    chk("fw_young", lk_data, 32'h22);
    lk_addr = 5'd0; #1;
    chk("fw_x0_hit", lk_hit, 0);
    chk("fw_x0_data", lk_data, 0);
    lk_addr = 5'd5; #1;
    chk("fw_miss_hit", lk_hit, 0);
    chk("fw_miss_data", lk_data, 0);
    lk_addr = 5'd7;
    rf_ready = 1'b1;
    tick();
    chk("fw_after_pop1", lk_data, 32'h22);
    chk("fw_after_pop1_ret", retired, 13);
    tick();
    chk("fw_after_pop2", lk_hit, 0);
    chk("t5_retired", retired, 14);

    // Mid-operation reset, then counter wrap
    rf_ready = 1'b0;
    lk_addr  = 5'd3;
    drive(mk(ADDI, 3, 0), 32'h0, 32'h33, 32'h0);
    tick();
    drive(mk(ADDI, 3, 0), 32'h0, 32'h44, 32'h0);
    tick();
    idle();
    #1;
    chk("pre_rst_hit", lk_hit, 1);
    rst = 1'b1;
    tick();
    chk("mrst_we", rf_we, 0);
    chk("mrst_hit", lk_hit, 0);
    chk("mrst_retired", retired, 0);
    chk("mrst_ld_err", ld_err, 0);
    chk("mrst_in_ready", in_ready, 0);
    rst = 1'b0;
    rf_ready = 1'b1;
    tick();
    chk("mrst_empty_we", rf_we, 0);
    chk("mrst_empty_ret", retired, 0);
    drive(mk(ADDI, 4, 0), 32'h0, 32'h1, 32'h0);
    repeat (17) tick();
    idle();
    tick();
    chk("wrap_retired", retired, 1);
    chk("wrap_we", rf_we, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
